// File: rtl/regfile_valid_pkg.sv
// Shared types and sizing for the register valid-bit tracker that sits beside
// the rename source map.
package regfile_valid_pkg;

  localparam int AREGS    = 32;
  localparam int QSLOTS   = 3;
  localparam int CSLOTS   = 2;
  localparam int RENTRIES = 16;
  localparam int RBIT     = $clog2(RENTRIES);

  typedef logic [4:0] reg_idx_t;

  // Latest-producer tag; nosrc=1 means the value already lives in the register file.
  typedef struct packed {
    logic            nosrc;
    logic [RBIT-1:0] rid;
  } tag_t;

endpackage

// File: rtl/regfile_valid_if.sv
// Dispatch, commit, source-map and flush signals feeding regfile_valid, plus
// the valid/ready flags it returns to the dispatch stage.
interface regfile_valid_if;
  import regfile_valid_pkg::*;

  logic                         branchmiss;
  logic [QSLOTS-1:0]            slotv;
  logic [QSLOTS-1:0]            queuedOn;
  logic [QSLOTS-1:0]            slot_rfw;
  logic [QSLOTS-1:0]            slot_srw;
  reg_idx_t [QSLOTS-1:0]        Rd;
  reg_idx_t [QSLOTS-1:0][1:0]   Rs;
  logic [CSLOTS-1:0]            commit_v;
  logic [CSLOTS-1:0]            commit_rfw;
  logic [CSLOTS-1:0]            commit_srw;
  reg_idx_t [CSLOTS-1:0]        commit_tgt;
  logic [CSLOTS-1:0][RBIT-1:0]  commit_rid;
  tag_t [AREGS-1:0]             rf_source;
  tag_t                         sr_source;
  logic [AREGS-1:0]             rob_pending_tgt;
  logic                         rob_pending_sr;
  logic [AREGS-1:0]             rf_v;
  logic                         sr_v;
  logic [QSLOTS-1:0][1:0]       src_rdy;

  modport master (
    output branchmiss, slotv, queuedOn, slot_rfw, slot_srw, Rd, Rs,
           commit_v, commit_rfw, commit_srw, commit_tgt, commit_rid,
           rf_source, sr_source, rob_pending_tgt, rob_pending_sr,
    input  rf_v, sr_v, src_rdy
  );

  modport slave (
    input  branchmiss, slotv, queuedOn, slot_rfw, slot_srw, Rd, Rs,
           commit_v, commit_rfw, commit_srw, commit_tgt, commit_rid,
           rf_source, sr_source, rob_pending_tgt, rob_pending_sr,
    output rf_v, sr_v, src_rdy
  );

endinterface

// File: rtl/regfile_valid_match.sv
// Per-register commit match: a commit counts only if its ROB id is still the
// register's latest producer in the source map.
module regfile_valid_match
  import regfile_valid_pkg::*;
(
  input  logic [CSLOTS-1:0]           i_commit_v,
  input  logic [CSLOTS-1:0]           i_commit_rfw,
  input  logic [CSLOTS-1:0]           i_commit_srw,
  input  reg_idx_t [CSLOTS-1:0]       i_commit_tgt,
  input  logic [CSLOTS-1:0][RBIT-1:0] i_commit_rid,
  input  tag_t [AREGS-1:0]            i_rf_source,
  input  tag_t                        i_sr_source,
  output logic [AREGS-1:0]            o_rf_match,
  output logic                        o_sr_match
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    o_rf_match = '0;
    o_sr_match = 1'b0;
    for (int c = 0; c < CSLOTS; c++) begin
      for (int r = 0; r < AREGS; r++) begin
        if (i_commit_v[c] && i_commit_rfw[c] && (i_commit_tgt[c] == reg_idx_t'(r)) &&
            !i_rf_source[r].nosrc && (i_rf_source[r].rid == i_commit_rid[c]))
          o_rf_match[r] = 1'b1;
      end
      if (i_commit_v[c] && i_commit_srw[c] &&
          !i_sr_source.nosrc && (i_sr_source.rid == i_commit_rid[c]))
        o_sr_match = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_valid.sv
// Architectural register / status register valid bits and registered operand
// ready flags for the dispatch stage.
module regfile_valid
  import regfile_valid_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  regfile_valid_if.slave bus
);

  logic [QSLOTS-1:0]      w_disp;
  logic [AREGS-1:0]       w_rf_match;
  logic                   w_sr_match;
  logic [AREGS-1:0]       w_rf_clr;
  logic                   w_sr_clr;
  logic [AREGS-1:0]       w_rf_next;
  logic                   w_sr_next;
  logic [QSLOTS-1:0][1:0] w_rdy_next;

  logic [AREGS-1:0]       r_rf_v;
  logic                   r_sr_v;
  logic [QSLOTS-1:0][1:0] r_src_rdy;

  regfile_valid_match u_match (
    .i_commit_v   (bus.commit_v),
    .i_commit_rfw (bus.commit_rfw),
    .i_commit_srw (bus.commit_srw),
    .i_commit_tgt (bus.commit_tgt),
    .i_commit_rid (bus.commit_rid),
    .i_rf_source  (bus.rf_source),
    .i_sr_source  (bus.sr_source),
    .o_rf_match   (w_rf_match),
    .o_sr_match   (w_sr_match)
  );

  // Dispatch is in order: the first valid slot that is not queued stalls every slot above it.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    w_disp  = '0;
    for (int k = 0; k < QSLOTS; k++) begin
      if (bus.slotv[k]) begin
        if (bus.queuedOn[k] && !blocked) w_disp[k] = 1'b1;
        else                             blocked   = 1'b1;
      end
    end
  end

  always_comb begin
    w_rf_clr = '0;
    w_sr_clr = 1'b0;
    for (int k = 0; k < QSLOTS; k++) begin
      if (w_disp[k] && bus.slot_rfw[k]) w_rf_clr[bus.Rd[k]] = 1'b1;
      if (w_disp[k] && bus.slot_srw[k]) w_sr_clr = 1'b1;
    end
  end

  // A new dispatch names a younger producer, so clearing wins over a same-cycle commit.
  always_comb begin
    if (bus.branchmiss) begin
      w_rf_next = ~bus.rob_pending_tgt;
      w_sr_next = ~bus.rob_pending_sr;
    end else begin
      w_rf_next = (r_rf_v | w_rf_match) & ~w_rf_clr;
      w_sr_next = (r_sr_v | w_sr_match) & ~w_sr_clr;
    end
    w_rf_next[0] = 1'b1;
  end

  always_comb begin
    logic     hit;
    reg_idx_t src;
    hit        = 1'b0;
    src        = '0;
    w_rdy_next = '0;
    for (int k = 0; k < QSLOTS; k++) begin
      for (int j = 0; j < 2; j++) begin
        src = bus.Rs[k][j];
        hit = 1'b0;
        for (int i = 0; i < k; i++)
          if (w_disp[i] && bus.slot_rfw[i] && (bus.Rd[i] == src)) hit = 1'b1;
        if (bus.branchmiss)  w_rdy_next[k][j] = 1'b0;
        else if (src == '0)  w_rdy_next[k][j] = 1'b1;
        else if (hit)        w_rdy_next[k][j] = 1'b0;
        else                 w_rdy_next[k][j] = r_rf_v[src] | w_rf_match[src];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_v    <= '1;
      r_sr_v    <= 1'b1;
      r_src_rdy <= '0;
    end else begin
      r_rf_v    <= w_rf_next;
      r_sr_v    <= w_sr_next;
      r_src_rdy <= w_rdy_next;
    end
  end

  assign bus.rf_v    = r_rf_v;
  assign bus.sr_v    = r_sr_v;
  assign bus.src_rdy = r_src_rdy;

endmodule

// File: tb/tb_regfile_valid.sv
// Scoreboard bench for regfile_valid: a behavioural model predicts each cycle's
// registered outputs, which are queued and compared one cycle later.
module tb_regfile_valid;
  import regfile_valid_pkg::*;

  typedef struct {
    string                  name;
    logic [AREGS-1:0]       rf_v;
    logic                   sr_v;
    logic [QSLOTS-1:0][1:0] src_rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_valid_if bus ();

  regfile_valid dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  logic [AREGS-1:0] m_rf_v;
  logic             m_sr_v;
  int               vectors     = 0;
  int               miscompares = 0;

  function automatic logic model_dispatched(input int k);
    if (!(bus.slotv[k] && bus.queuedOn[k])) return 1'b0;
    for (int i = 0; i < k; i++)
      if (bus.slotv[i] && !bus.queuedOn[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_rf_match(input int r);
    logic m = 1'b0;
    for (int c = 0; c < CSLOTS; c++)
      if (bus.commit_v[c] && bus.commit_rfw[c] && int'(bus.commit_tgt[c]) == r &&
          bus.rf_source[r] == {1'b0, bus.commit_rid[c]})
        m = 1'b1;
    return m;
  endfunction

  function automatic logic model_sr_match();
    logic m = 1'b0;
    for (int c = 0; c < CSLOTS; c++)
      if (bus.commit_v[c] && bus.commit_srw[c] && bus.sr_source == {1'b0, bus.commit_rid[c]})
        m = 1'b1;
    return m;
  endfunction

  task automatic idle();
    bus.branchmiss      = 1'b0;
    bus.slotv           = '0;
    bus.queuedOn        = '0;
    bus.slot_rfw        = '0;
    bus.slot_srw        = '0;
    bus.Rd              = '0;
    bus.Rs              = '0;
    bus.commit_v        = '0;
    bus.commit_rfw      = '0;
    bus.commit_srw      = '0;
    bus.commit_tgt      = '0;
    bus.commit_rid      = '0;
    bus.rob_pending_tgt = '0;
    bus.rob_pending_sr  = 1'b0;
    for (int r = 0; r < AREGS; r++) bus.rf_source[r] = {1'b1, 4'h0};
    bus.sr_source = {1'b1, 4'h0};
  endtask

  // Predict next outputs from current inputs, queue them, clock once, then pop and compare.
  task automatic apply(input string name);
    exp_t     e;
    exp_t     got;
    logic     clr;
    logic     blk;
    reg_idx_t src;
    e.name = name;
    for (int r = 0; r < AREGS; r++) begin
      if (r == 0) e.rf_v[r] = 1'b1;
      else if (bus.branchmiss) e.rf_v[r] = !bus.rob_pending_tgt[r];
      else begin
        clr = 1'b0;
        for (int k = 0; k < QSLOTS; k++)
          if (model_dispatched(k) && bus.slot_rfw[k] && int'(bus.Rd[k]) == r) clr = 1'b1;
        e.rf_v[r] = clr ? 1'b0 : (model_rf_match(r) ? 1'b1 : m_rf_v[r]);
      end
    end
    if (bus.branchmiss) e.sr_v = !bus.rob_pending_sr;
    else begin
      clr = 1'b0;
      for (int k = 0; k < QSLOTS; k++)
        if (model_dispatched(k) && bus.slot_srw[k]) clr = 1'b1;
      e.sr_v = clr ? 1'b0 : (model_sr_match() ? 1'b1 : m_sr_v);
    end
    for (int k = 0; k < QSLOTS; k++) begin
      for (int j = 0; j < 2; j++) begin
        src = bus.Rs[k][j];
        if (bus.branchmiss) e.src_rdy[k][j] = 1'b0;
        else if (src == 5'd0) e.src_rdy[k][j] = 1'b1;
        else begin
          blk = 1'b0;
          for (int i = 0; i < k; i++)
            if (model_dispatched(i) && bus.slot_rfw[i] && bus.Rd[i] == src) blk = 1'b1;
          e.src_rdy[k][j] = blk ? 1'b0 : (m_rf_v[src] | model_rf_match(int'(src)));
        end
      end
    end
    sb.push_back(e);
    m_rf_v = e.rf_v;
    m_sr_v = e.sr_v;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    vectors++;
    if (bus.rf_v !== got.rf_v) begin
      miscompares++;
      $display("FAIL %s rf_v: got %h expected %h", got.name, bus.rf_v, got.rf_v);
    end
    vectors++;
    if (bus.sr_v !== got.sr_v) begin
      miscompares++;
      $display("FAIL %s sr_v: got %b expected %b", got.name, bus.sr_v, got.sr_v);
    end
    vectors++;
    if (bus.src_rdy !== got.src_rdy) begin
      miscompares++;
      $display("FAIL %s src_rdy: got %h expected %h", got.name, bus.src_rdy, got.src_rdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    m_rf_v = '1;
    m_sr_v = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.rf_v !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_rf_v: got %h expected ffffffff", bus.rf_v);
    end
    vectors++;
    if (bus.sr_v !== 1'b1 || bus.src_rdy !== 6'h00) begin
      miscompares++;
      $display("FAIL reset_sr_src: got sr_v=%b src_rdy=%h expected 1/00", bus.sr_v, bus.src_rdy);
    end
    rst = 1'b0;
    #2;
  endtask

  task automatic test_dispatch_clear();
    idle();
    bus.slotv = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001; bus.Rd[0] = 5'd5;
    apply("disp_rd5");
    vectors++;
    if (bus.rf_v[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL disp_rd5_bit: got %b expected 0", bus.rf_v[5]);
    end
  endtask

  task automatic test_commit();
    idle();
    bus.rf_source[5] = {1'b0, 4'd3};
    bus.commit_v = 2'b01; bus.commit_rfw = 2'b01; bus.commit_tgt[0] = 5'd5; bus.commit_rid[0] = 4'd3;
    apply("commit_match");
    vectors++;
    if (bus.rf_v[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL commit_match_bit: got %b expected 1", bus.rf_v[5]);
    end
    idle();
    bus.slotv = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001; bus.Rd[0] = 5'd5;
    apply("reclear_rd5");
    idle();
    bus.rf_source[5] = {1'b0, 4'd3};
    bus.commit_v = 2'b10; bus.commit_rfw = 2'b10; bus.commit_tgt[1] = 5'd5; bus.commit_rid[1] = 4'd2;
    apply("commit_stale");
    vectors++;
    if (bus.rf_v[5] !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_stale_bit: got %b expected 0", bus.rf_v[5]);
    end
    bus.rf_source[5] = {1'b1, 4'd2};
    apply("commit_nosrc");
  endtask

  task automatic test_dispatch_beats_commit();
    idle();
    bus.slotv = 3'b011; bus.queuedOn = 3'b011; bus.slot_rfw = 3'b010; bus.Rd[1] = 5'd7;
    bus.rf_source[7] = {1'b0, 4'd1};
    bus.commit_v = 2'b01; bus.commit_rfw = 2'b01; bus.commit_tgt[0] = 5'd7; bus.commit_rid[0] = 4'd1;
    apply("disp_vs_commit");
    vectors++;
    if (bus.rf_v[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL disp_vs_commit_bit: got %b expected 0", bus.rf_v[7]);
    end
  endtask

  task automatic test_src_rdy();
    idle();
    bus.slotv = 3'b111; bus.queuedOn = 3'b111; bus.slot_rfw = 3'b101;
    bus.Rd[0] = 5'd9; bus.Rd[2] = 5'd9; bus.Rs[2][0] = 5'd9; bus.Rs[0][0] = 5'd9; bus.Rs[1][1] = 5'd7;
    apply("fwd_older_slot");
    vectors++;
    if (bus.src_rdy[2][0] !== 1'b0 || bus.src_rdy[0][0] !== 1'b1) begin
      miscompares++;
      $display("FAIL fwd_older_slot_bits: got s2r0=%b s0r0=%b expected 0/1", bus.src_rdy[2][0], bus.src_rdy[0][0]);
    end
    idle();
    bus.slotv = 3'b111; bus.queuedOn = 3'b101; bus.slot_rfw = 3'b101;
    bus.Rd[0] = 5'd10; bus.Rd[2] = 5'd11; bus.Rs[2][0] = 5'd10; bus.Rs[2][1] = 5'd11;
    apply("blocked_slot2");
    vectors++;
    if (bus.rf_v[11:10] !== 2'b10) begin
      miscompares++;
      $display("FAIL blocked_slot2_bits: got %b expected 10", bus.rf_v[11:10]);
    end
    idle();
    bus.rf_source[9] = {1'b0, 4'd6};
    bus.commit_v = 2'b10; bus.commit_rfw = 2'b10; bus.commit_tgt[1] = 5'd9; bus.commit_rid[1] = 4'd6;
    bus.Rs[0][0] = 5'd9; bus.Rs[1][1] = 5'd10;
    apply("commit_bypass");
    vectors++;
    if (bus.src_rdy[0][0] !== 1'b1 || bus.src_rdy[1][1] !== 1'b0) begin
      miscompares++;
      $display("FAIL commit_bypass_bits: got %b/%b expected 1/0", bus.src_rdy[0][0], bus.src_rdy[1][1]);
    end
  endtask

  task automatic test_status_reg();
    idle();
    bus.slotv = 3'b100; bus.queuedOn = 3'b100; bus.slot_srw = 3'b100;
    apply("sr_dispatch");
    idle();
    bus.sr_source = {1'b0, 4'd4};
    bus.commit_v = 2'b11; bus.commit_srw = 2'b11; bus.commit_rid[0] = 4'd1; bus.commit_rid[1] = 4'd4;
    apply("sr_two_commits");
    vectors++;
    if (bus.sr_v !== 1'b1) begin
      miscompares++;
      $display("FAIL sr_two_commits_bit: got %b expected 1", bus.sr_v);
    end
  endtask

  task automatic test_branchmiss();
    idle();
    bus.Rs[0][0] = 5'd0; bus.Rs[1][0] = 5'd1;
    apply("pre_miss");
    idle();
    bus.branchmiss = 1'b1; bus.rob_pending_tgt = 32'h0000_0030;
    bus.slotv = 3'b001; bus.queuedOn = 3'b001; bus.slot_rfw = 3'b001; bus.Rd[0] = 5'd8;
    apply("branchmiss");
    vectors++;
    if (bus.rf_v !== 32'hFFFF_FFCF || bus.src_rdy !== 6'h00) begin
      miscompares++;
      $display("FAIL branchmiss_const: got rf_v=%h src_rdy=%h expected ffffffcf/00", bus.rf_v, bus.src_rdy);
    end
  endtask

  task automatic test_back_to_back();
    int tgt;
    for (int n = 0; n < 60; n++) begin
      idle();
      for (int r = 0; r < AREGS; r++) begin
        bus.rf_source[r].nosrc = ($urandom_range(0, 3) == 0);
        bus.rf_source[r].rid   = 4'($urandom_range(0, 15));
      end
      bus.sr_source = {1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15))};
      bus.slotv    = 3'($urandom);
      bus.queuedOn = 3'($urandom);
      bus.slot_rfw = 3'($urandom);
      bus.slot_srw = 3'($urandom_range(0, 7) & 3'($urandom));
      for (int k = 0; k < QSLOTS; k++) begin
        bus.Rd[k]    = 5'($urandom_range(0, 15));
        bus.Rs[k][0] = 5'($urandom_range(0, 15));
        bus.Rs[k][1] = 5'($urandom_range(0, 15));
      end
      for (int c = 0; c < CSLOTS; c++) begin
        tgt = $urandom_range(0, 15);
        bus.commit_v[c]   = 1'($urandom);
        bus.commit_rfw[c] = 1'($urandom);
        bus.commit_srw[c] = 1'($urandom);
        bus.commit_tgt[c] = 5'(tgt);
        bus.commit_rid[c] = ($urandom_range(0, 1) == 1) ? bus.rf_source[tgt].rid : 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        bus.branchmiss      = 1'b1;
        bus.rob_pending_tgt = $urandom;
        bus.rob_pending_sr  = 1'($urandom);
      end
      apply("random");
    end
  endtask

  task automatic test_async_reset();
    idle();
    bus.slotv = 3'b011; bus.queuedOn = 3'b011; bus.slot_rfw = 3'b011;
    bus.Rd[0] = 5'd0; bus.Rd[1] = 5'd3;
    apply("rd0_dispatch");
    vectors++;
    if (bus.rf_v[0] !== 1'b1 || bus.rf_v[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL rd0_dispatch_bits: got r0=%b r3=%b expected 1/0", bus.rf_v[0], bus.rf_v[3]);
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rf_v !== 32'hFFFF_FFFF || bus.sr_v !== 1'b1 || bus.src_rdy !== 6'h00) begin
      miscompares++;
      $display("FAIL async_reset: got rf_v=%h sr_v=%b src_rdy=%h expected ffffffff/1/00",
               bus.rf_v, bus.sr_v, bus.src_rdy);
    end
    m_rf_v = '1;
    m_sr_v = 1'b1;
    sb.delete();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dispatch_clear();
    test_commit();
    test_dispatch_beats_commit();
    test_src_rdy();
    test_status_reg();
    test_branchmiss();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
